// File: rtl/mul_div_unit_pkg.sv
// Shared types, constants and result helpers for the RV32M multiply/divide unit.
package mul_div_unit_pkg;

  localparam int unsigned MULDIV_XLEN           = 32;
  localparam int unsigned MULDIV_DIV_ITERATIONS = 32;
  localparam int unsigned MULDIV_CNT_W          = $clog2(MULDIV_DIV_ITERATIONS);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } MulDivOp;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } MulDivState;

  function automatic logic is_div_op(input MulDivOp op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input MulDivOp op);
    return op[2] && !op[0];
  endfunction

  function automatic logic [MULDIV_XLEN-1:0] magnitude(input logic [MULDIV_XLEN-1:0] x,
                                                       input logic neg);
    return neg ? MULDIV_XLEN'(-x) : x;
  endfunction

  // Divide by zero or the single signed overflow case
  function automatic logic div_is_special(input MulDivOp op,
                                          input logic [MULDIV_XLEN-1:0] a,
                                          input logic [MULDIV_XLEN-1:0] b);
    return (b == '0) ||
           (is_signed_div(op) && a == 32'h8000_0000 && b == '1);
  endfunction

  // Re-apply signs to the magnitude quotient/remainder and override the special cases
  function automatic logic [MULDIV_XLEN-1:0] div_fixup(input MulDivOp op,
                                                       input logic [MULDIV_XLEN-1:0] a,
                                                       input logic [MULDIV_XLEN-1:0] b,
                                                       input logic [MULDIV_XLEN-1:0] q_mag,
                                                       input logic [MULDIV_XLEN-1:0] r_mag);
    logic                   sgn;
    logic [MULDIV_XLEN-1:0] q;
    logic [MULDIV_XLEN-1:0] r;
    sgn = is_signed_div(op);
    q   = magnitude(q_mag, sgn && (a[MULDIV_XLEN-1] ^ b[MULDIV_XLEN-1]));
    r   = magnitude(r_mag, sgn && a[MULDIV_XLEN-1]);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == '1) begin
      q = 32'h8000_0000;
      r = '0;
    end
    return op[1] ? r : q;
  endfunction

  function automatic logic [MULDIV_XLEN-1:0] mul_result(input MulDivOp op,
                                                        input logic [MULDIV_XLEN-1:0] a,
                                                        input logic [MULDIV_XLEN-1:0] b);
    logic signed [MULDIV_XLEN:0]     ea;
    logic signed [MULDIV_XLEN:0]     eb;
    logic signed [2*MULDIV_XLEN+1:0] p;
    ea = {((op == OP_MULH) || (op == OP_MULHSU)) && a[MULDIV_XLEN-1], a};
    eb = {(op == OP_MULH) && b[MULDIV_XLEN-1], b};
    p  = (2*MULDIV_XLEN+2)'(ea) * (2*MULDIV_XLEN+2)'(eb);
    return (op == OP_MUL) ? p[MULDIV_XLEN-1:0] : p[2*MULDIV_XLEN-1:MULDIV_XLEN];
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter_core.sv
// Restoring radix-2 divider datapath: remainder/quotient shift registers and trial subtract.
module div_iter_core
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient_next_c,
  output logic [WIDTH-1:0] remainder_next_c
);

  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // One quotient bit: shift in the next dividend bit and keep the difference if non-negative
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_q};
    if (trial[WIDTH]) begin
      remainder_next_c = shifted[WIDTH-1:0];
      quotient_next_c  = {quotient[WIDTH-2:0], 1'b0};
    end else begin
      remainder_next_c = trial[WIDTH-1:0];
      quotient_next_c  = {quotient[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
    end else if (step) begin
      quotient  <= quotient_next_c;
      remainder <= remainder_next_c;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit with structure-hazard handshake and flush.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete one cycle after start.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  clear,
  output logic                  isBusy,
  output logic                  resultValid,
  output logic [DATA_WIDTH-1:0] result
);

  MulDivState              state_q, state_d;
  MulDivOp                 op_q, op_d, in_op;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   result_d;
  logic                    valid_d;
  logic                    core_load, core_step;
  logic [DATA_WIDTH-1:0]   dividend_mag, divisor_mag;
  logic [DATA_WIDTH-1:0]   quo, rem, quo_next, rem_next;

  assign in_op        = MulDivOp'(op);
  assign dividend_mag = magnitude(op1, is_signed_div(in_op) && op1[DATA_WIDTH-1]);
  assign divisor_mag  = magnitude(op2, is_signed_div(in_op) && op2[DATA_WIDTH-1]);

  assign isBusy = (state_q == ST_IDLE && start && !clear) ||
                  (state_q == ST_MUL) || (state_q == ST_DIV);

  div_iter_core #(.WIDTH(DATA_WIDTH)) u_core (
    .clk              (clk),
    .rst              (rst),
    .load             (core_load),
    .step             (core_step),
    .dividend         (dividend_mag),
    .divisor          (divisor_mag),
    .quotient         (quo),
    .remainder        (rem),
    .quotient_next_c  (quo_next),
    .remainder_next_c (rem_next)
  );

  // Next-state and registered-output logic; clear wins over everything but reset
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    result_d  = result;
    valid_d   = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d = in_op;
            a_d  = op1;
            b_d  = op2;
            if (!is_div_op(in_op)) begin
              state_d = ST_MUL;
            end else begin
              cnt_d     = '0;
              core_load = 1'b1;
              state_d   = ST_DIV;
`ifdef MULDIV_EARLY_OUT_EN
              if (div_is_special(in_op, op1, op2)) begin
                core_load = 1'b0;
                state_d   = ST_DONE;
                valid_d   = 1'b1;
                result_d  = div_fixup(in_op, op1, op2, '0, '0);
              end
`endif
            end
          end
        end
        ST_MUL: begin
          result_d = mul_result(op_q, a_q, b_q);
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
        ST_DIV: begin
          core_step = 1'b1;
          cnt_d     = MULDIV_CNT_W'(cnt_q + 1'b1);
          if (cnt_q == MULDIV_CNT_W'(MULDIV_DIV_ITERATIONS - 1)) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            result_d = div_fixup(op_q, a_q, b_q, quo_next, rem_next);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      result      <= '0;
      resultValid <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      result      <= result_d;
      resultValid <= valid_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (honours MULDIV_EARLY_OUT_EN when defined).
module tb_mul_div_unit;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPC_LAT = 1;
`else
  localparam int SPC_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, start, clear;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic        isBusy, resultValid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .op1         (op1),
    .op2         (op2),
    .clear       (clear),
    .isBusy      (isBusy),
    .resultValid (resultValid),
    .result      (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle (T); returns at the negedge of the IDLE cycle after DONE.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    start = 1'b1;
    op    = o;
    op1   = a;
    op2   = b;
    #1;
    chk({tag, " busy@T"}, 32'(isBusy), 32'd1);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i < lat) begin
        chk({tag, " busy"}, 32'(isBusy), 32'd1);
        chk({tag, " early valid"}, 32'(resultValid), 32'd0);
      end else begin
        chk({tag, " valid"}, 32'(resultValid), 32'd1);
        chk({tag, " result"}, result, exp);
        chk({tag, " busy@done"}, 32'(isBusy), 32'd0);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, " single pulse"}, 32'(resultValid), 32'd0);
    chk({tag, " result held"}, result, exp);
    chk({tag, " idle busy"}, 32'(isBusy), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    op    = 3'b000;
    op1   = '0;
    op2   = '0;
    repeat (2) @(negedge clk);
    chk("reset result", result, 32'h0);
    chk("reset valid", 32'(resultValid), 32'd0);
    chk("reset busy", 32'(isBusy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul 7*-3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh min*min", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    run_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
    run_op("divu 100/0", DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
    run_op("remu 100/0", REMU, 32'd100, 32'd0, 32'd100, SPC_LAT);
    run_op("div -5/0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
    run_op("rem -5/0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPC_LAT);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);

    // Flush a divide at T+10, then a multiply issued at T+11 completes at T+13
    start = 1'b1;
    op    = DIV;
    op1   = 32'd1000;
    op2   = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("clear div no valid", 32'(resultValid), 32'd0);
    end
    chk("clear busy before", 32'(isBusy), 32'd1);
    clear = 1'b1;
    start = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clear idle busy", 32'(isBusy), 32'd0);
    chk("clear no valid", 32'(resultValid), 32'd0);
    chk("clear result kept", result, 32'h0);
    run_op("mul after clear", MUL, 32'd6, 32'd7, 32'd42, MUL_LAT);

    // Reset mid-multiply zeroes result and produces no pulse
    start = 1'b1;
    op    = MUL;
    op1   = 32'd5;
    op2   = 32'd5;
    @(negedge clk);
    chk("rst mul busy", 32'(isBusy), 32'd1);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst result", result, 32'h0);
    chk("rst valid", 32'(resultValid), 32'd0);
    chk("rst busy", 32'(isBusy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst no late valid", 32'(resultValid), 32'd0);
    chk("rst result stays", result, 32'h0);

    run_op("mul after rst", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

RV32M multiply/divide execution unit for the execute stage, and the responder to the pipeline controller's structure-hazard protocol. It accepts one operation per start, raises `isBusy` for the same cycle so the controller stalls the pipeline, and returns the result with `resultValid`. It drops any in-flight operation when the controller asserts `clear` on a branch miss. Multiplies complete in two cycles; divides and remainders iterate one bit per cycle.

## Interface
- `DATA_WIDTH`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  core clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  execute stage holds an M-extension instruction; level, held until the stage advances.
- `op`  in  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `op1`  in  DATA_WIDTH  rs1 value, already bypassed.
- `op2`  in  DATA_WIDTH  rs2 value, already bypassed.
- `clear`  in  1  flush from the controller (`mulDivClear`).
- `isBusy`  out  1  structure hazard to the controller; combinational.
- `resultValid`  out  1  `result` is valid in this cycle.
- `result`  out  DATA_WIDTH  operation result.

## Operation
- The FSM has four states: IDLE, MUL, DIV, DONE. Reset state is IDLE. Reset values: `resultValid`=0, `result`=0, iteration counter=0.
- IDLE with `start`=1 and `clear`=0: latch `op`, `op1`, `op2`.
  - MUL ops go to MUL.
  - DIV/REM ops go to DIV with the counter at 0.
- MUL: register the 64-bit product of the sign- or zero-extended operands, then go to DONE.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
  - MULHSU extends rs1 as signed and rs2 as unsigned.
- DIV: restoring radix-2 algorithm on magnitudes, one quotient bit per cycle. After counter = 31, go to DONE.
  - Signed ops: negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / −1): quotient = 0x80000000, remainder = 0.
- DONE: `resultValid`=1 and `result` is stable. Next state is IDLE unconditionally. A `start` still high in DONE belongs to the completing instruction and is ignored.
- `isBusy` = (state==IDLE && `start` && !`clear`) || state==MUL || state==DIV. `isBusy` is 0 in DONE, so the stage advances.
- `clear` has priority over `start`. In any state it forces IDLE at the next edge, with `resultValid`=0 and no result produced. Latched operands are discarded.
- `rst` has priority over `clear`. Reset applied mid-operation behaves like `clear` and also zeroes `result`.

## Timing
- `start` sampled at cycle T:
  - MUL family: `isBusy` high in T and T+1; `resultValid` high in T+2.
  - DIV/REM family: `isBusy` high in T through T+32; `resultValid` high in T+33.
- `resultValid` is a single-cycle pulse. `result` holds its value until the next completion.
- Back-to-back operations: a new `start` is accepted in the IDLE cycle that follows DONE. Minimum spacing is 3 cycles for multiplies and 34 for divides.
- `clear` sampled at cycle C: the FSM is in IDLE at C+1, and `isBusy`=0 in C+1 unless a new `start` arrives.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined:
  - Divide-by-zero and signed-overflow DIV/REM go from IDLE directly to DONE.
  - For those cases, `isBusy` is high only in T and `resultValid` is high in T+1.
  - Values are identical to the iterative path.
- Macro undefined: every DIV/REM takes the full 33-cycle path, and the special values come from the end-of-iteration fix-up logic.

## Structure
- Shared package holds:
  - the `MulDivOp` enum, with encodings equal to funct3;
  - the `MulDivState` enum;
  - `MULDIV_DIV_ITERATIONS` = 32.
- Sub-module `div_iter_core`: remainder/quotient shift registers and the trial subtract, with `load` and `step` controls. Sign handling, special cases and the FSM stay in the top module.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `result`=0xFFFFFFEB at T+2; `isBusy` high exactly in T and T+1.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD at T+33. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - Valid at T+33 with the macro undefined, at T+1 with it defined.
- DIV started at T, `clear`=1 at T+10 → IDLE at T+11 with `isBusy`=0. No `resultValid` pulse occurs. A new MUL started at T+11 completes at T+13.
- `start` held high through DONE → exactly one `resultValid` pulse.
- `rst` asserted during MUL → IDLE next cycle with `result`=0 and `resultValid`=0.
